// File: rtl/pool_pkg.sv
// Shared definitions for the pooling / unpooling datapath blocks.
package pool_pkg;

    // Defaults shared with avg_pool_unit so both ends of a pool/unpool pair agree.
    localparam int unsigned DefFactor = 4;
    localparam int unsigned DefOutW   = 32;

    // Group-emission FSM encoding.
    typedef enum logic {
        StIdle = 1'b0,
        StEmit = 1'b1
    } pool_state_e;

endpackage

// File: rtl/avg_unpool_unit.sv
// Average unpooling: each accepted signed 8-bit value is replayed FACTOR times,
// sign-extended to OUT_W and scaled by a left shift.
module avg_unpool_unit
    import pool_pkg::*;
#(
    parameter int unsigned FACTOR      = DefFactor,
    parameter int unsigned OUT_W       = DefOutW,
    parameter int unsigned SCALE_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [7:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(FACTOR)-1:0] out_idx,
    output logic                      out_last,
    output logic                      busy
);

    localparam int unsigned     IdxW    = $clog2(FACTOR);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FACTOR - 1);

    pool_state_e       state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic signed [7:0] hold_q, hold_d;
    logic              en_q;

    logic                    in_hs;
    logic                    out_hs;
    logic                    at_last;
    logic signed [OUT_W-1:0] ext;

    assign at_last   = (cnt_q == LastIdx);
    assign out_valid = (state_q == StEmit);
    assign busy      = (state_q == StEmit);
    assign out_idx   = cnt_q;
    assign out_last  = at_last && out_valid;
    // en_q keeps in_ready low while in reset and opens it on the first clock after release.
    assign in_ready  = en_q && ((state_q == StIdle) || (out_last && out_ready));
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Size cast of a signed operand sign-extends; the shift then truncates to OUT_W.
    assign ext      = OUT_W'(hold_q);
    assign out_data = busy ? (ext <<< SCALE_SHIFT) : '0;

    // Next-state: capture on input handshake, advance per output beat, reload on last beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (in_hs) begin
                    state_d = StEmit;
                    hold_d  = in_data;
                    cnt_d   = '0;
                end
            end
            StEmit: begin
                if (out_hs) begin
                    if (at_last) begin
                        cnt_d = '0;
                        if (in_hs) begin
                            hold_d = in_data;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + IdxW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any group in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            en_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avg_unpool_unit.sv
// Self-checking bench for avg_unpool_unit: directed scenarios plus random traffic,
// checked every cycle against a beat-queue reference model.
module tb_avg_unpool_unit;

    localparam int unsigned FACTOR = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [1:0]        out_idx;
    logic              out_last;
    logic              busy;

    logic              in_ready2;
    logic              out_valid2;
    logic [31:0]       out_data2;
    logic [1:0]        out_idx2;
    logic              out_last2;
    logic              busy2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int val;
        int idx;
    } beat_t;

    beat_t q[$];
    bit    model_en;
    int    beats_done;

    avg_unpool_unit #(
        .FACTOR     (FACTOR),
        .OUT_W      (32),
        .SCALE_SHIFT(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    avg_unpool_unit #(
        .FACTOR     (FACTOR),
        .OUT_W      (32),
        .SCALE_SHIFT(2)
    ) dut_s2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready2),
        .in_data  (in_data),
        .out_valid(out_valid2),
        .out_ready(out_ready),
        .out_data (out_data2),
        .out_idx  (out_idx2),
        .out_last (out_last2),
        .busy     (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        return model_en && ((q.size() == 0) || (q.size() == 1 && out_ready));
    endfunction

    // Compare every output of both instances against the model.
    task automatic check_all(input string tag);
        bit          v;
        logic [31:0] d0, d2;
        int          idx;
        v   = (q.size() != 0);
        idx = v ? q[0].idx : 0;
        d0  = v ? 32'(q[0].val) : 32'd0;
        d2  = v ? 32'(q[0].val * 4) : 32'd0;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(v));
        chk({tag, ".out_data"}, out_data, d0);
        chk({tag, ".out_idx"}, 32'(out_idx), 32'(idx));
        chk({tag, ".out_last"}, 32'(out_last), 32'(v && idx == FACTOR - 1));
        chk({tag, ".s2.out_data"}, out_data2, d2);
        chk({tag, ".s2.in_ready"}, 32'(in_ready2), 32'(exp_ready()));
    endtask

    // One clock: drive, check at negedge, advance the model at posedge.
    task automatic cyc(input string tag, input logic iv, input logic [7:0] d, input logic ordy);
        bit ihs, ohs;
        int v;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        check_all(tag);
        ihs = iv && exp_ready();
        ohs = ordy && (q.size() != 0);
        v   = int'($signed(d));
        @(posedge clk);
        if (ohs) begin
            void'(q.pop_front());
            beats_done++;
        end
        if (ihs) begin
            for (int i = 0; i < FACTOR; i++) q.push_back('{val: v, idx: i});
        end
        model_en = 1'b1;
        #1;
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #1;
        q.delete();
        model_en = 1'b0;
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        model_en   = 1'b0;
        beats_done = 0;

        // Reset state, with in_valid asserted to show it is ignored.
        #2;
        in_valid = 1'b1;
        in_data  = 8'sd99;
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("post_rst", 1'b0, 8'd0, 1'b1);
        cyc("idle", 1'b0, 8'd0, 1'b1);

        // Single group of 5.
        cyc("g5.in", 1'b1, 8'sd5, 1'b1);
        for (int i = 0; i < 5; i++) cyc("g5", 1'b0, 8'd0, 1'b1);

        // -128, checked scaled by 4 on the shifted instance.
        cyc("g128.in", 1'b1, 8'h80, 1'b1);
        for (int i = 0; i < 5; i++) cyc("g128", 1'b0, 8'd0, 1'b1);

        // Stall pattern 1,0,0,1,1,1: four beats finish in six cycles.
        cyc("stall.in", 1'b1, 8'sd42, 1'b1);
        beats_done = 0;
        cyc("stall1", 1'b1, 8'sd11, 1'b1);
        cyc("stall2", 1'b1, 8'sd11, 1'b0);
        cyc("stall3", 1'b1, 8'sd11, 1'b0);
        cyc("stall4", 1'b0, 8'sd11, 1'b1);
        cyc("stall5", 1'b0, 8'sd11, 1'b1);
        cyc("stall6", 1'b0, 8'sd11, 1'b1);
        chk("stall.beats", 32'(beats_done), 32'd4);
        chk("stall.busy_end", 32'(busy), 32'd0);

        // Back-to-back groups 3 then 7 with no bubble.
        cyc("b2b.in3", 1'b1, 8'sd3, 1'b1);
        beats_done = 0;
        for (int i = 0; i < 4; i++) cyc("b2b.in7", 1'b1, 8'sd7, 1'b1);
        for (int i = 0; i < 4; i++) cyc("b2b.tail", 1'b0, 8'd0, 1'b1);
        chk("b2b.beats", 32'(beats_done), 32'd8);

        // Reset after beat 1, then a fresh group of 9.
        cyc("rst.in", 1'b1, 8'sd21, 1'b1);
        cyc("rst.b0", 1'b0, 8'd0, 1'b1);
        cyc("rst.b1", 1'b0, 8'd0, 1'b1);
        apply_reset("mid_rst");
        cyc("rst.rel", 1'b0, 8'd0, 1'b1);
        cyc("g9.in", 1'b1, 8'sd9, 1'b1);
        for (int i = 0; i < 5; i++) cyc("g9", 1'b0, 8'd0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 12; i++) cyc("drain", 1'b0, 8'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avg_unpool_unit.md
AVG_UNPOOL_UNIT -- requirements
Module: avg_unpool_unit

Interface
REQ-001 Parameter FACTOR, default 4: number of output beats per accepted input; legal range 2..16.
REQ-002 Parameter OUT_W, default 32: output data width; legal range 8..32.
REQ-003 Parameter SCALE_SHIFT, default 0: left-shift applied to each output; legal range 0..OUT_W-8.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  8  signed pooled value.
REQ-009 out_valid  output  1  out_data is valid this cycle.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  OUT_W  signed expanded element.
REQ-012 out_idx  output  clog2(FACTOR)  index of the current beat within its group.
REQ-013 out_last  output  1  current beat is index FACTOR-1.
REQ-014 busy  output  1  high while a group is being emitted.

Function
REQ-015 An input handshake SHALL occur when in_valid && in_ready; an output handshake SHALL occur when out_valid && out_ready.
REQ-016 The FSM SHALL have two states: IDLE and EMIT.
REQ-017 IDLE -> EMIT on an input handshake; the value SHALL be captured into a hold register and the beat counter cleared to 0.
REQ-018 EMIT: out_valid=1 and out_data = sign_extend(hold, OUT_W) <<< SCALE_SHIFT, truncated to OUT_W.
REQ-019 out_idx SHALL equal the beat counter; out_last SHALL equal (counter == FACTOR-1) && out_valid.
REQ-020 In EMIT, on an output handshake with counter < FACTOR-1, the counter SHALL increment by 1.
REQ-021 On the output handshake of the last beat: if an input handshake occurs in the same cycle, the block SHALL reload hold, clear the counter and stay in EMIT; otherwise it SHALL go to IDLE.
REQ-022 in_ready SHALL be (state==IDLE) || (state==EMIT && out_last && out_ready), giving back-to-back groups with no bubble.
REQ-023 While out_valid && !out_ready, out_data, out_idx and out_last SHALL hold stable.
REQ-024 Latency: after an input handshake at edge N, beat 0 SHALL be valid in the cycle following edge N.
REQ-025 Throughput: one beat per cycle when out_ready=1; FACTOR cycles per input.
REQ-026 in_valid while in_ready=0 SHALL be ignored; in_data SHALL NOT be sampled.
REQ-027 busy SHALL equal (state==EMIT).
REQ-028 In IDLE, out_data SHALL be 0.

Reset
REQ-029 Asserting rst (low) SHALL immediately force IDLE, counter=0, hold=0, out_valid=0, out_data=0, out_idx=0, out_last=0 and busy=0.
REQ-030 During reset, in_ready SHALL be 0; after deassertion, in_ready SHALL be 1 from the first clock.
REQ-031 Reset during EMIT SHALL discard the remaining beats of the group; no partial group SHALL resume.

Structure
REQ-032 Shared package pool_pkg SHALL hold the FSM state encoding and the default FACTOR and OUT_W constants used with avg_pool_unit.
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 Reset release, in_data=8'sd5, in_valid=1 for one cycle, out_ready=1 -> four beats of out_data=5, out_idx=0..3, out_last only on idx 3, then IDLE.
REQ-035 in_data=-8'sd128 with SCALE_SHIFT=2 -> out_data=32'hFFFF_FE00 on all four beats.
REQ-036 out_ready toggled 1,0,0,1,1,1 -> outputs held stable during stalls; four beats complete at cycle 6.
REQ-037 Continuous in_valid with values 3 then 7, out_ready=1 -> eight consecutive beats (3x4, 7x4); in_ready high only in idle and on the last-beat cycle; no bubble.
REQ-038 rst asserted after beat 1 of a group -> outputs zero immediately; after release, a fresh input of 9 produces four beats starting at out_idx=0.
